// File: rtl/fc_input_sequencer.sv
// fc_input_sequencer
//   Upstream feeder of the fully-connected PE layer. Serially collects one
//   activation vector (INPUT_NODES words, word 0 in the LSBs), holds it stable,
//   then sweeps OUTPUT_NODES weight rows out of the weight ROM. Each
//   {activation vector, weight row} pair is offered to the PE array with a
//   valid/ready handshake. Per node: FETCH (ROM read), CAPT (latch row),
//   PRESENT (wait for pe_ready).
//
// Optional feature macro: FC_SEQ_STALL_CNT_EN
//   When defined, adds output stall_cnt: the number of PRESENT cycles with
//   pe_ready=0 since the last accepted start. It saturates at all-ones.
//
// Ports
//   clk, reset        clock (rising edge); asynchronous active-low reset
//   start             begin load + sweep (only honoured in IDLE)
//   act_data/valid    serial activation input; act_ready high in LOAD only
//   w_rd_en, w_addr   weight ROM read strobe / row address (FETCH only)
//   w_rdata           ROM row, valid one cycle after w_rd_en
//   input_fc          packed activation vector to the PEs
//   input_weights     packed weight row to the PEs
//   pe_valid/ready    handshake for the presented pair
//   node_idx          output node of the presented pair
//   busy              high in every state except IDLE
//   done              one-cycle pulse after the last node is accepted
//   stall_cnt         (FC_SEQ_STALL_CNT_EN only) PRESENT back-pressure cycles
module fc_input_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int INPUT_NODES  = 120,
  parameter int OUTPUT_NODES = 1200,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             act_data,
  input  logic                              act_valid,
  output logic                              act_ready,
  output logic                              w_rd_en,
  output logic [ADDR_WIDTH-1:0]             w_addr,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0] w_rdata,
  output logic [DATA_WIDTH*INPUT_NODES-1:0] input_fc,
  output logic [DATA_WIDTH*INPUT_NODES-1:0] input_weights,
  output logic                              pe_valid,
  input  logic                              pe_ready,
  output logic [ADDR_WIDTH-1:0]             node_idx,
  output logic                              busy,
`ifdef FC_SEQ_STALL_CNT_EN
  output logic [31:0]                       stall_cnt,
`endif
  output logic                              done
);

  localparam int VW = DATA_WIDTH * INPUT_NODES;
  localparam int CW = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_CAPT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_act_cnt;
  logic [ADDR_WIDTH-1:0] r_node;
  logic [VW-1:0]         r_fc;
  logic [VW-1:0]         r_wt;

  logic w_start_acc;
  logic w_act_fire;
  logic w_last_act;
  logic w_pe_fire;
  logic w_last_node;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_act_fire  = (r_state == S_LOAD) && act_valid;
  assign w_last_act  = (r_act_cnt == CW'(INPUT_NODES - 1));
  assign w_pe_fire   = (r_state == S_PRESENT) && pe_ready;
  assign w_last_node = (r_node == ADDR_WIDTH'(OUTPUT_NODES - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next    = r_state;
    act_ready = 1'b0;
    w_rd_en   = 1'b0;
    pe_valid  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        act_ready = 1'b1;
        if (w_act_fire && w_last_act) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_rd_en = 1'b1;
        w_next  = S_CAPT;
      end
      S_CAPT: w_next = S_PRESENT;
      S_PRESENT: begin
        pe_valid = 1'b1;
        if (pe_ready) w_next = w_last_node ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters and vector registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act_cnt <= '0;
      r_node    <= '0;
      r_fc      <= '0;
      r_wt      <= '0;
    end else begin
      if (w_start_acc) begin
        r_act_cnt <= '0;
        r_node    <= '0;
      end
      // Counter stops at the last word instead of wrapping; state leaves LOAD.
      if (w_act_fire && !w_last_act) r_act_cnt <= r_act_cnt + 1'b1;
      for (int i = 0; i < INPUT_NODES; i++) begin
        if (w_act_fire && (r_act_cnt == CW'(i)))
          r_fc[i*DATA_WIDTH +: DATA_WIDTH] <= act_data;
      end
      // ROM row arrives the cycle after the FETCH strobe.
      if (r_state == S_CAPT) r_wt <= w_rdata;
      if (w_pe_fire && !w_last_node) r_node <= r_node + 1'b1;
    end
  end

  assign input_fc      = r_fc;
  assign input_weights = r_wt;
  assign w_addr        = r_node;
  assign node_idx      = r_node;

`ifdef FC_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_PRESENT) && !pe_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fc_input_sequencer.sv
module tb_fc_input_sequencer;

  localparam int DW = 16;
  localparam int IN = 4;
  localparam int ON = 3;
  localparam int AW = 2;
  localparam int VW = DW * IN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] act_data = '0;
  logic          act_valid = 1'b0;
  logic          act_ready;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [VW-1:0] w_rdata = '0;
  logic [VW-1:0] input_fc;
  logic [VW-1:0] input_weights;
  logic          pe_valid;
  logic          pe_ready = 1'b0;
  logic [AW-1:0] node_idx;
  logic          busy;
  logic          done;
`ifdef FC_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  fc_input_sequencer #(
    .DATA_WIDTH  (DW),
    .INPUT_NODES (IN),
    .OUTPUT_NODES(ON),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .act_data     (act_data),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .w_rd_en      (w_rd_en),
    .w_addr       (w_addr),
    .w_rdata      (w_rdata),
    .input_fc     (input_fc),
    .input_weights(input_weights),
    .pe_valid     (pe_valid),
    .pe_ready     (pe_ready),
    .node_idx     (node_idx),
    .busy         (busy),
`ifdef FC_SEQ_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] fc;
    logic [VW-1:0] wt;
    int            node;
  } exp_t;

  exp_t          exp_q[$];
  int            fetch_q[$];
  logic [VW-1:0] rom [0:ON-1];
  int            n_chk = 0;
  int            n_fail = 0;
  int            done_seen = 0;
  int            exp_done = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected at %0t", nm, $time);
  endtask

  // Weight ROM: row valid one cycle after the read strobe, junk otherwise.
  initial begin
    logic          rd;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      rd = w_rd_en;
      a  = w_addr;
      @(posedge clk);
      #1;
      w_rdata = rd ? rom[a] : {$urandom, $urandom};
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!busy) chk("act_ready_idle", 64'(act_ready), 64'(0));
      if (w_rd_en) begin
        if (fetch_q.size() == 0) fail("w_rd_en_unexpected");
        else chk("w_addr", 64'(w_addr), 64'(fetch_q.pop_front()));
      end
      if (pe_valid && pe_ready) begin
        if (exp_q.size() == 0) begin
          fail("pe_handshake_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("input_fc", input_fc, e.fc);
          chk("input_weights", input_weights, e.wt);
          chk("node_idx", 64'(node_idx), 64'(e.node));
        end
      end
      if (done) begin
        done_seen++;
        chk("done_all_nodes_accepted", 64'(exp_q.size()), 64'(0));
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_act_ready"}, 64'(act_ready), 64'(0));
    chk({tag, "_pe_valid"}, 64'(pe_valid), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_w_rd_en"}, 64'(w_rd_en), 64'(0));
    chk({tag, "_input_fc"}, input_fc, 64'(0));
    chk({tag, "_input_weights"}, input_weights, 64'(0));
    chk({tag, "_node_idx"}, 64'(node_idx), 64'(0));
    chk({tag, "_w_addr"}, 64'(w_addr), 64'(0));
`ifdef FC_SEQ_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
`endif
  endtask

  // Push the expected sweep, issue start, and stream in the activation words.
  task automatic load_vec(input logic [VW-1:0] v, input bit gap);
    int idx;
    int cyc;
    bit vld;
    bit rdy;
    for (int n = 0; n < ON; n++) begin
      exp_q.push_back('{v, rom[n], n});
      fetch_q.push_back(n);
    end
    exp_done++;
    act_valid = 1'b1;
    act_data  = 16'hdead;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef FC_SEQ_STALL_CNT_EN
    chk("stall_cnt_cleared_on_start", 64'(stall_cnt), 64'(0));
`endif
    idx = 0;
    cyc = 0;
    while (idx < IN && cyc < 200) begin
      vld       = gap ? (cyc % 3 == 0) : 1'b1;
      act_valid = vld;
      act_data  = vld ? v[idx*DW +: DW] : DW'($urandom);
      rdy       = act_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (vld && rdy) idx++;
    end
    act_valid = 1'b0;
    if (idx < IN) fail("load_timeout");
    chk("input_fc_after_load", input_fc, v);
    chk("act_ready_after_load", 64'(act_ready), 64'(0));
  endtask

  task automatic sweep(input logic [VW-1:0] v, input bit rnd, input int stall_node,
                       input int stall_len, input bit poke);
    int cyc;
    int stalled;
    bit poked;
    cyc = 0;
    stalled = 0;
    poked = 1'b0;
    while (!done && cyc < 300) begin
      if (pe_valid && int'(node_idx) == stall_node && stalled < stall_len) begin
        pe_ready = 1'b0;
        stalled++;
        chk("stall_node_idx", 64'(node_idx), 64'(stall_node));
        chk("stall_input_fc", input_fc, v);
        chk("stall_input_weights", input_weights, rom[stall_node]);
      end else begin
        pe_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (poke && pe_valid && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    pe_ready = 1'b0;
    if (!done) fail("sweep_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", 64'(done_seen), 64'(exp_done));
    chk("idle_after_sweep", 64'(busy), 64'(0));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    chk("fetches_drained", 64'(fetch_q.size()), 64'(0));
  endtask

  initial begin
    logic [VW-1:0] v;
    int cyc;
    for (int n = 0; n < ON; n++) rom[n] = {$urandom, $urandom};

    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    v = 64'h0004_0003_0002_0001;
    load_vec(v, 1'b0);
    sweep(v, 1'b0, -1, 0, 1'b0);

    load_vec(v, 1'b1);
    sweep(v, 1'b0, -1, 0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      v = {$urandom, $urandom};
      load_vec(v, t[0]);
      sweep(v, 1'b1, -1, 0, 1'b0);
    end

    v = {$urandom, $urandom};
    load_vec(v, 1'b0);
    sweep(v, 1'b0, 1, 5, 1'b0);
`ifdef FC_SEQ_STALL_CNT_EN
    chk("stall_cnt_after_stall", 64'(stall_cnt), 64'(5));
`endif

    v = {$urandom, $urandom};
    load_vec(v, 1'b0);
    sweep(v, 1'b0, -1, 0, 1'b1);

    // Reset while node 1 is being presented, then restart from scratch.
    v = {$urandom, $urandom};
    load_vec(v, 1'b0);
    cyc = 0;
    while (!(pe_valid && node_idx == AW'(1)) && cyc < 100) begin
      pe_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    pe_ready = 1'b0;
    if (!(pe_valid && node_idx == AW'(1))) fail("reach_node1_timeout");
    #2 reset = 1'b0;
    #1;
    chk_reset_state("midsweep_reset");
    exp_q.delete();
    fetch_q.delete();
    exp_done--;
    @(posedge clk);
    #1;
    chk_reset_state("midsweep_reset_held");
    reset = 1'b1;

    v = {$urandom, $urandom};
    load_vec(v, 1'b0);
    sweep(v, 1'b0, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
